// File: rtl/alu_clz_pkg.sv
// Shared types and constants for the iterative CLZ/CLO functional unit.
package alu_clz_pkg;

  localparam int unsigned N_DEF       = 32;
  localparam int unsigned SLICE_W_DEF = 8;
  localparam int unsigned TAG_W_DEF   = 4;

  localparam int unsigned NSLICE = N_DEF / SLICE_W_DEF;
  localparam int unsigned CNT_W  = $clog2(N_DEF) + 1;

  localparam logic OP_CLZ = 1'b0;
  localparam logic OP_CLO = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } clz_state_t;

endpackage

// File: rtl/alu_logic_clz.sv
// Combinational count-leading-zeros over an N-bit word; y == N when the word is zero.
module alu_logic_clz #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]      a,
  output logic [$clog2(N):0] y,
  output logic              all_zero
);

  localparam int unsigned YW = $clog2(N) + 1;

  // Scanning upward lets the highest set bit win.
  always_comb begin
    y = YW'(N);
    for (int unsigned i = 0; i < N; i++) begin
      if (a[i]) y = YW'(N - 1 - i);
    end
  end

  assign all_zero = ~|a;

endmodule

// File: rtl/alu_clz_seq.sv
// Multi-cycle CLZ/CLO unit: scans the operand MSB-first one slice per cycle,
// stopping at the first non-empty slice.
module alu_clz_seq
  import alu_clz_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned SLICE_W = SLICE_W_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_op,
  input  logic [N-1:0]      in_a,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [$clog2(N):0] out_count,
  output logic              out_all,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int unsigned NumSlice = N / SLICE_W;
  localparam int unsigned CntW     = $clog2(N) + 1;
  localparam int unsigned SCntW    = $clog2(SLICE_W) + 1;
  localparam int unsigned IdxW     = (NumSlice > 1) ? $clog2(NumSlice) : 1;

  clz_state_t         state_q;
  logic [N-1:0]       opr_q;
  logic [TAG_W-1:0]   tag_q;
  logic [IdxW-1:0]    idx_q;
  logic [CntW-1:0]    acc_q;

  logic [N-1:0]       opr_shift;
  logic [SLICE_W-1:0] slice;
  logic [SCntW-1:0]   slice_clz;
  logic               slice_zero;
  logic               accept;
  logic               last_slice;

  assign opr_shift  = opr_q << (idx_q * SLICE_W);
  assign slice      = opr_shift[N-1 -: SLICE_W];
  assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept     = in_valid && in_ready && !flush;
  assign last_slice = (idx_q == IdxW'(NumSlice - 1));

  alu_logic_clz #(
    .N (SLICE_W)
  ) u_slice_clz (
    .a        (slice),
    .y        (slice_clz),
    .all_zero (slice_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opr_q     <= '0;
      tag_q     <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_all   <= 1'b0;
      out_tag   <= '0;
      busy      <= 1'b0;
    end else if (flush) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        SCAN: begin
          if (!slice_zero) begin
            out_count <= acc_q + CntW'(slice_clz);
            out_all   <= 1'b0;
            out_tag   <= tag_q;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else if (last_slice) begin
            out_count <= CntW'(N);
            out_all   <= 1'b1;
            out_tag   <= tag_q;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            acc_q <= acc_q + CntW'(SLICE_W);
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
      // A new accept (IDLE, or DONE handing off) overrides the case above.
      if (accept) begin
        opr_q   <= (in_op == OP_CLO) ? ~in_a : in_a;
        tag_q   <= in_tag;
        idx_q   <= '0;
        acc_q   <= '0;
        busy    <= 1'b1;
        state_q <= SCAN;
      end
    end
  end

endmodule

// File: tb/tb_alu_clz_seq.sv
// Self-checking bench for alu_clz_seq: directed cases plus randomized CLZ/CLO against a model.
module tb_alu_clz_seq;

  localparam int N       = 32;
  localparam int SLICE_W = 8;
  localparam int NSLICE  = N / SLICE_W;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [31:0] in_a;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_count;
  logic        out_all;
  logic [3:0]  out_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_clz_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_all   (out_all),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leading zeros of the (possibly inverted) operand, counted bit by bit.
  function automatic int ref_count(input logic op, input logic [31:0] a);
    logic [31:0] v;
    int c;
    v = op ? ~a : a;
    c = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) break;
      c++;
    end
    return c;
  endfunction

  function automatic int ref_latency(input int c);
    return (c >= N) ? NSLICE : (c / SLICE_W) + 1;
  endfunction

  // Waits up to a bounded number of edges for out_valid; returns edges taken.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 20);
  endtask

  // Issue one request, check result and latency, then drain it.
  task automatic run_op(input string name, input logic op, input logic [31:0] a,
                        input logic [3:0] tag);
    int c;
    int n;
    c = ref_count(op, a);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_tag   = tag;
    #1;
    check_eq({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_op    = ~op;
    in_tag   = ~tag;
    wait_valid(n);
    check_eq({name, "_lat"}, 32'(n), 32'(ref_latency(c)));
    check_eq({name, "_count"}, 32'(out_count), 32'(c));
    check_eq({name, "_all"}, 32'(out_all), 32'(c == N));
    check_eq({name, "_tag"}, 32'(out_tag), 32'(tag));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({name, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    logic saw_valid;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_count", 32'(out_count), 32'd0);
    rst_n = 1'b1;

    run_op("clz_00f0", 1'b0, 32'h00F0_0000, 4'd1);
    run_op("clz_zero", 1'b0, 32'h0000_0000, 4'd2);
    run_op("clo_ff0f", 1'b1, 32'hFFFF_FF0F, 4'd3);
    run_op("clo_ones", 1'b1, 32'hFFFF_FFFF, 4'd4);
    run_op("clz_msb", 1'b0, 32'h8000_0000, 4'd5);
    run_op("clz_lsb", 1'b0, 32'h0000_0001, 4'd6);

    // Back-pressure, then same-cycle hand-off to a new request.
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b0; in_a = 32'h0F00_0000; in_tag = 4'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(n);
    check_eq("bp_first_count", 32'(out_count), 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_count", 32'(out_count), 32'd4);
      check_eq("bp_tag", 32'(out_tag), 32'd9);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 1'b0; in_a = 32'h0001_0000; in_tag = 4'd7;
    #1;
    check_eq("bp_handoff_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("bp_handoff_valid", 32'(out_valid), 32'd0);
    check_eq("bp_handoff_busy", 32'(busy), 32'd1);
    wait_valid(n);
    check_eq("bp_second_lat", 32'(n), 32'd2);
    check_eq("bp_second_count", 32'(out_count), 32'd15);
    check_eq("bp_second_tag", 32'(out_tag), 32'd7);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Flush mid-scan of an all-zero operand.
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b0; in_a = 32'h0; in_tag = 4'd11;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_eq("flush_busy", 32'(busy), 32'd0);
    check_eq("flush_in_ready", 32'(in_ready), 32'd1);
    check_eq("flush_count_kept", 32'(out_count), 32'd15);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check_eq("flush_no_valid", 32'(saw_valid), 32'd0);

    // Flush together with a request in IDLE drops the request.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_a = 32'h1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-scan.
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b0; in_a = 32'h0; in_tag = 4'd13;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_count", 32'(out_count), 32'd0);
    check_eq("arst_tag", 32'(out_tag), 32'd0);
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check_eq("arst_no_valid", 32'(saw_valid), 32'd0);

    // Randomized operands with a spread of leading-run lengths.
    for (int i = 0; i < 40; i++) begin
      logic        op;
      logic [31:0] a;
      op = 1'($urandom_range(0, 1));
      a  = $urandom >> $urandom_range(0, 32);
      if (op) a = ~a;
      run_op("rand", op, a, 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
